// File: rtl/binary_to_ascii_tx_if.sv
// rtl/binary_to_ascii_tx_if.sv - start/value request and ASCII character stream bundle
interface binary_to_ascii_tx_if #(
   parameter int DATA_W = 16
);
   logic              start;
   logic [DATA_W-1:0] value;
   logic              busy;
   logic              done;
   logic [7:0]        char_out;
   logic              char_valid;
   logic              char_ready;

   modport slave (
      input  start,
      input  value,
      input  char_ready,
      output busy,
      output done,
      output char_out,
      output char_valid
   );

   modport master (
      output start,
      output value,
      output char_ready,
      input  busy,
      input  done,
      input  char_out,
      input  char_valid
   );
endinterface

// File: rtl/binary_to_ascii_tx.sv
// rtl/binary_to_ascii_tx.sv - binary to decimal ASCII streamer with optional CR/LF
module binary_to_ascii_tx #(
   parameter int DATA_W      = 16,
   parameter int NUM_DIGITS  = 5,
   parameter int APPEND_CRLF = 1
) (
   input logic                  clk,
   input logic                  rst_n,
   binary_to_ascii_tx_if.slave  bus
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int PTR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CONVERT,
      ST_EMIT,
      ST_CR,
      ST_LF
   } state_t;

   state_t             state_q, state_d;
   logic [DATA_W-1:0]  value_q, value_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic               done_q, done_d;

   logic [BCD_W-1:0]   bcd_adj;
   logic [PTR_W-1:0]   lead_ptr;
   logic [3:0]         cur_digit;
   logic [7:0]         char_c;
   logic               valid_c;

   // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
   always_comb begin
      bcd_adj = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end else begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
         end
      end
   end

   // Priority encode of the most-significant nonzero digit; all-zero falls back to digit 0.
   always_comb begin
      lead_ptr = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] != 4'd0) begin
            lead_ptr = PTR_W'(i);
         end
      end
   end

   // Select the digit currently addressed by the emit pointer.
   always_comb begin
      cur_digit = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (ptr_q == PTR_W'(i)) begin
            cur_digit = bcd_q[4*i +: 4];
         end
      end
   end

   // Next-state logic and character presentation.
   always_comb begin
      state_d = state_q;
      value_d = value_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      done_d  = 1'b0;
      char_c  = 8'h00;
      valid_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               value_d = bus.value;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = ST_CONVERT;
            end
         end

         ST_CONVERT: begin
            // DATA_W shift cycles, then one cycle where the final BCD value
            // is stable so the leading-digit encode sees the finished result.
            if (cnt_q == CNT_W'(DATA_W)) begin
               ptr_d   = lead_ptr;
               state_d = ST_EMIT;
            end else begin
               bcd_d   = {bcd_adj[BCD_W-2:0], value_q[DATA_W-1]};
               value_d = value_q << 1;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end

         ST_EMIT: begin
            char_c  = 8'h30 + {4'h0, cur_digit};
            valid_c = 1'b1;
            if (bus.char_ready) begin
               if (ptr_q == '0) begin
                  if (APPEND_CRLF != 0) begin
                     state_d = ST_CR;
                  end else begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  ptr_d = ptr_q - PTR_W'(1);
               end
            end
         end

         ST_CR: begin
            char_c  = 8'h0D;
            valid_c = 1'b1;
            if (bus.char_ready) begin
               state_d = ST_LF;
            end
         end

         ST_LF: begin
            char_c  = 8'h0A;
            valid_c = 1'b1;
            if (bus.char_ready) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any conversion in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         value_q <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         value_q <= value_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.done       = done_q;
   assign bus.char_out   = char_c;
   assign bus.char_valid = valid_c;

endmodule

// File: tb/tb_binary_to_ascii_tx.sv
// tb/tb_binary_to_ascii_tx.sv - randomized self-checking bench for binary_to_ascii_tx
module tb_binary_to_ascii_tx;

   typedef logic [7:0] u8;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   binary_to_ascii_tx_if #(.DATA_W(16)) if_a ();
   binary_to_ascii_tx_if #(.DATA_W(16)) if_b ();

   binary_to_ascii_tx #(.DATA_W(16), .NUM_DIGITS(5), .APPEND_CRLF(1)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_a)
   );

   binary_to_ascii_tx #(.DATA_W(16), .NUM_DIGITS(5), .APPEND_CRLF(0)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference: decimal digits by repeated division, then optional CR LF.
   task automatic build_exp(input int unsigned v, input bit crlf, output u8 q[$]);
      int unsigned t;
      q = {};
      t = v;
      if (t == 0) q.push_back(8'h30);
      while (t > 0) begin
         q.push_front(u8'(48 + (t % 10)));
         t = t / 10;
      end
      if (crlf) begin
         q.push_back(8'h0D);
         q.push_back(8'h0A);
      end
   endtask

   task automatic start_conv(input bit sel, input logic [15:0] v);
      @(negedge clk);
      if (sel) begin if_b.start = 1'b1; if_b.value = v; end
      else     begin if_a.start = 1'b1; if_a.value = v; end
      @(posedge clk);
      #1;
      if (sel) if_b.start = 1'b0; else if_a.start = 1'b0;
   endtask

   // Runs one conversion from cycle 0 (just after the accept edge) to done,
   // checking the received string, stall stability, busy and done behaviour.
   task automatic collect(input bit sel, input string tag, input int rmode,
                          input bit inject, input bit bb, input logic [15:0] bb_val,
                          input bit chk_lat, input u8 exp_q[$]);
      u8  got[$];
      u8  ch, pchar;
      int c, first, done_c, stall_err, busy_err, bad_idx;
      bit fin, pv_stall, v, rdy, d, b;
      got = {};
      c = 0; first = -1; done_c = -1; stall_err = 0; busy_err = 0;
      fin = 0; pv_stall = 0; pchar = 8'h00;
      while (!fin && c < 400) begin
         rdy = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (sel) if_b.char_ready = rdy; else if_a.char_ready = rdy;
         if (inject) begin
            if_a.start = (c == 5 || c == 18);
            if_a.value = (c == 5 || c == 18) ? 16'd999 : 16'($urandom);
         end
         @(negedge clk);
         v  = sel ? if_b.char_valid : if_a.char_valid;
         ch = sel ? if_b.char_out   : if_a.char_out;
         d  = sel ? if_b.done       : if_a.done;
         b  = sel ? if_b.busy       : if_a.busy;
         if (pv_stall && (!v || ch !== pchar)) stall_err++;
         if (v && first < 0) first = c;
         if (d) begin
            fin = 1;
            done_c = c;
            n_checks++;
            if (b !== 1'b0 || v !== 1'b0)
               $display("FAIL %s_done_cycle busy=%b valid=%b required busy=0 valid=0", tag, b, v);
            else n_pass++;
            if (bb) begin
               if (sel) begin if_b.start = 1'b1; if_b.value = bb_val; end
               else     begin if_a.start = 1'b1; if_a.value = bb_val; end
            end
         end else if (!b) begin
            busy_err++;
         end
         if (v && rdy) got.push_back(ch);
         pv_stall = v && !rdy;
         pchar = ch;
         @(posedge clk);
         #1;
         c++;
      end
      if (inject) if_a.start = 1'b0;
      if (sel) if_b.start = 1'b0; else if_a.start = 1'b0;

      n_checks++;
      if (!fin) $display("FAIL %s_timeout done not seen within %0d cycles", tag, c);
      else n_pass++;

      n_checks++;
      if ((sel ? if_b.done : if_a.done) !== 1'b0)
         $display("FAIL %s_done_width done still 1 after pulse cycle, required 0", tag);
      else n_pass++;

      n_checks++;
      if ((sel ? if_b.busy : if_a.busy) !== bb)
         $display("FAIL %s_busy_after busy=%b required %b", tag, (sel ? if_b.busy : if_a.busy), bb);
      else n_pass++;

      bad_idx = -1;
      if (got.size() != exp_q.size()) bad_idx = 999;
      else foreach (got[i]) if (got[i] !== exp_q[i] && bad_idx < 0) bad_idx = i;
      n_checks++;
      if (bad_idx == 999)
         $display("FAIL %s_length got %0d chars required %0d", tag, got.size(), exp_q.size());
      else if (bad_idx >= 0)
         $display("FAIL %s_char[%0d] got %h required %h", tag, bad_idx, got[bad_idx], exp_q[bad_idx]);
      else n_pass++;

      n_checks++;
      if (stall_err != 0) $display("FAIL %s_stall_stable %0d unstable stall cycles, required 0", tag, stall_err);
      else n_pass++;

      n_checks++;
      if (busy_err != 0) $display("FAIL %s_busy_high busy low on %0d cycles, required 0", tag, busy_err);
      else n_pass++;

      if (chk_lat) begin
         n_checks++;
         if (first != 17) $display("FAIL %s_first_valid cycle %0d required 17", tag, first);
         else n_pass++;
         n_checks++;
         if (done_c != 17 + exp_q.size())
            $display("FAIL %s_done_latency cycle %0d required %0d", tag, done_c, 17 + exp_q.size());
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (if_a.busy !== 1'b0 || if_a.done !== 1'b0 || if_a.char_valid !== 1'b0 || if_a.char_out !== 8'h00)
         $display("FAIL reset_outputs busy=%b done=%b valid=%b char=%h required 0 0 0 00",
                  if_a.busy, if_a.done, if_a.char_valid, if_a.char_out);
      else n_pass++;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (if_a.busy !== 1'b0 || if_b.busy !== 1'b0 || if_a.char_valid !== 1'b0)
         $display("FAIL reset_idle busy_a=%b busy_b=%b valid=%b required 0 0 0",
                  if_a.busy, if_b.busy, if_a.char_valid);
      else n_pass++;
   endtask

   task automatic test_zero();
      u8 e[$];
      build_exp(0, 1, e);
      start_conv(0, 16'd0);
      collect(0, "zero", 0, 0, 0, 16'd0, 1, e);
   endtask

   task automatic test_max();
      u8 e[$];
      build_exp(65535, 1, e);
      start_conv(0, 16'd65535);
      collect(0, "max", 0, 0, 0, 16'd0, 1, e);
   endtask

   task automatic test_stall();
      u8 e[$];
      build_exp(1204, 1, e);
      start_conv(0, 16'd1204);
      collect(0, "stall1204", 1, 0, 0, 16'd0, 0, e);
   endtask

   task automatic test_ignore_start();
      u8 e[$];
      build_exp(42, 1, e);
      start_conv(0, 16'd42);
      collect(0, "ignore", 0, 1, 0, 16'd0, 1, e);
   endtask

   task automatic test_reset_abort();
      u8  e[$];
      int cnt;
      start_conv(0, 16'd31337);
      if_a.char_ready = 1'b1;
      cnt = 0;
      while (!if_a.char_valid && cnt < 40) begin
         @(posedge clk); #1; cnt++;
      end
      n_checks++;
      if (if_a.char_valid !== 1'b1 || if_a.char_out !== 8'h33)
         $display("FAIL abort_first valid=%b char=%h required 1 33", if_a.char_valid, if_a.char_out);
      else n_pass++;
      @(posedge clk); #1;
      if_a.char_ready = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      n_checks++;
      if (if_a.char_valid !== 1'b1 || if_a.char_out !== 8'h31)
         $display("FAIL abort_stalled valid=%b char=%h required 1 31", if_a.char_valid, if_a.char_out);
      else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (if_a.char_valid !== 1'b0 || if_a.busy !== 1'b0 || if_a.done !== 1'b0)
         $display("FAIL abort_async valid=%b busy=%b done=%b required 0 0 0",
                  if_a.char_valid, if_a.busy, if_a.done);
      else n_pass++;
      if_a.char_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (if_a.char_valid !== 1'b0 || if_a.done !== 1'b0)
         $display("FAIL abort_quiet valid=%b done=%b required 0 0", if_a.char_valid, if_a.done);
      else n_pass++;
      build_exp(7, 1, e);
      start_conv(0, 16'd7);
      collect(0, "after_abort", 0, 0, 0, 16'd0, 1, e);
   endtask

   task automatic test_back_to_back();
      u8 e[$];
      build_exp(10, 0, e);
      start_conv(1, 16'd10);
      collect(1, "nocrlf10", 0, 0, 1, 16'd5, 1, e);
      build_exp(5, 0, e);
      collect(1, "nocrlf5", 0, 0, 0, 16'd0, 1, e);
   endtask

   task automatic test_random();
      u8           e[$];
      logic [15:0] v;
      bit          sel;
      for (int k = 0; k < 10; k++) begin
         v   = 16'($urandom);
         if (k == 0) v = 16'd100;
         if (k == 1) v = 16'd9;
         sel = (k % 3 == 2);
         build_exp(int'(v), !sel, e);
         start_conv(sel, v);
         collect(sel, $sformatf("rand%0d_%0d", k, v), 1, 0, 0, 16'd0, 0, e);
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      if_a.start = 1'b0; if_a.value = '0; if_a.char_ready = 1'b0;
      if_b.start = 1'b0; if_b.value = '0; if_b.char_ready = 1'b0;
      test_reset();
      test_zero();
      test_max();
      test_stall();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
